// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
// Requester ids are also the values held by the round-robin pointer.
package rf_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rf_access_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer names the requester that wins a tie
// and is moved to the other requester whenever a grant is taken.
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  output logic winner,
  output logic any_req
);

  logic r_ptr;

  always_comb begin
    any_req = req_a | req_b;
    if (req_a && req_b) begin
      winner = r_ptr;
    end else if (req_b) begin
      winner = REQ_B;
    end else begin
      winner = REQ_A;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr <= REQ_A;
    end else if (advance) begin
      r_ptr <= ~winner;
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Serialises read/write commands from two requesters onto one register-file
// port and steers read data back to the requester that issued the read.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic [DATA_W-1:0] rf_rd_data
);

  state_t              r_state;
  logic                r_cmd_we;
  logic                r_cmd_id;
  logic                r_gnt_a;
  logic                r_gnt_b;
  logic                r_rvalid_a;
  logic                r_rvalid_b;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;
  logic                r_rf_wr_en;
  logic                r_rf_rd_en;
  logic [ADDR_W-1:0]   r_rf_address;
  logic [DATA_W-1:0]   r_rf_wr_data;

  state_t              w_state_next;
  logic                w_cmd_we_next;
  logic                w_cmd_id_next;
  logic                w_gnt_a_next;
  logic                w_gnt_b_next;
  logic                w_rvalid_a_next;
  logic                w_rvalid_b_next;
  logic [DATA_W-1:0]   w_rdata_a_next;
  logic [DATA_W-1:0]   w_rdata_b_next;
  logic                w_rf_wr_en_next;
  logic                w_rf_rd_en_next;
  logic [ADDR_W-1:0]   w_rf_address_next;
  logic [DATA_W-1:0]   w_rf_wr_data_next;

  logic                w_winner;
  logic                w_any_req;
  logic                w_advance;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;

  // Requests are only looked at in IDLE, so the pointer moves once per grant.
  assign w_advance = (r_state == IDLE) && w_any_req;

  rr_arb2 u_rr_arb2 (
    .CLK     (CLK),
    .RST     (RST),
    .req_a   (req_a),
    .req_b   (req_b),
    .advance (w_advance),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  assign w_win_we    = (w_winner == REQ_B) ? we_b    : we_a;
  assign w_win_addr  = (w_winner == REQ_B) ? addr_b  : addr_a;
  assign w_win_wdata = (w_winner == REQ_B) ? wdata_b : wdata_a;

  always_comb begin
    w_state_next      = r_state;
    w_cmd_we_next     = r_cmd_we;
    w_cmd_id_next     = r_cmd_id;
    w_gnt_a_next      = 1'b0;
    w_gnt_b_next      = 1'b0;
    w_rvalid_a_next   = 1'b0;
    w_rvalid_b_next   = 1'b0;
    w_rdata_a_next    = r_rdata_a;
    w_rdata_b_next    = r_rdata_b;
    w_rf_wr_en_next   = 1'b0;
    w_rf_rd_en_next   = 1'b0;
    w_rf_address_next = '0;
    w_rf_wr_data_next = '0;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          // The ISSUE-cycle outputs are loaded straight from the winner here.
          w_state_next      = ISSUE;
          w_cmd_we_next     = w_win_we;
          w_cmd_id_next     = w_winner;
          w_gnt_a_next      = (w_winner == REQ_A);
          w_gnt_b_next      = (w_winner == REQ_B);
          w_rf_wr_en_next   = w_win_we;
          w_rf_rd_en_next   = ~w_win_we;
          w_rf_address_next = w_win_addr;
          w_rf_wr_data_next = w_win_we ? w_win_wdata : '0;
        end
      end
      ISSUE: begin
        w_state_next = r_cmd_we ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        w_state_next = IDLE;
        if (r_cmd_id == REQ_B) begin
          w_rdata_b_next  = rf_rd_data;
          w_rvalid_b_next = 1'b1;
        end else begin
          w_rdata_a_next  = rf_rd_data;
          w_rvalid_a_next = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_cmd_we     <= 1'b0;
      r_cmd_id     <= REQ_A;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_rvalid_a   <= 1'b0;
      r_rvalid_b   <= 1'b0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_rf_address <= '0;
      r_rf_wr_data <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cmd_we     <= w_cmd_we_next;
      r_cmd_id     <= w_cmd_id_next;
      r_gnt_a      <= w_gnt_a_next;
      r_gnt_b      <= w_gnt_b_next;
      r_rvalid_a   <= w_rvalid_a_next;
      r_rvalid_b   <= w_rvalid_b_next;
      r_rdata_a    <= w_rdata_a_next;
      r_rdata_b    <= w_rdata_b_next;
      r_rf_wr_en   <= w_rf_wr_en_next;
      r_rf_rd_en   <= w_rf_rd_en_next;
      r_rf_address <= w_rf_address_next;
      r_rf_wr_data <= w_rf_wr_data_next;
    end
  end

  assign gnt_a      = r_gnt_a;
  assign gnt_b      = r_gnt_b;
  assign rvalid_a   = r_rvalid_a;
  assign rvalid_b   = r_rvalid_b;
  assign rdata_a    = r_rdata_a;
  assign rdata_b    = r_rdata_b;
  assign rf_wr_en   = r_rf_wr_en;
  assign rf_rd_en   = r_rf_rd_en;
  assign rf_address = r_rf_address;
  assign rf_wr_data = r_rf_wr_data;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter with a behavioural 16x16 register file behind it.
// Expected read data is queued per requester when a read is presented.
module tb_rf_access_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rf_wr_en, rf_rd_en;
  logic [AW-1:0] rf_address;
  logic [DW-1:0] rf_wr_data;
  logic [DW-1:0] rf_rd_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] exp_mem[16];
  logic [DW-1:0] rf_mem[16];

  always #5 CLK = ~CLK;

  rf_access_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_a      (req_a),
    .we_a       (we_a),
    .addr_a     (addr_a),
    .wdata_a    (wdata_a),
    .gnt_a      (gnt_a),
    .rvalid_a   (rvalid_a),
    .rdata_a    (rdata_a),
    .req_b      (req_b),
    .we_b       (we_b),
    .addr_b     (addr_b),
    .wdata_b    (wdata_b),
    .gnt_b      (gnt_b),
    .rvalid_b   (rvalid_b),
    .rdata_b    (rdata_b),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_en   (rf_rd_en),
    .rf_address (rf_address),
    .rf_wr_data (rf_wr_data),
    .rf_rd_data (rf_rd_data)
  );

  // Register file: read data appears the cycle after RdEn is sampled.
  always @(posedge CLK) begin
    if (rf_wr_en) rf_mem[rf_address] <= rf_wr_data;
    if (rf_rd_en) rf_rd_data <= rf_mem[rf_address];
  end

  task automatic set_a(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_a = r; we_a = w; addr_a = a; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_b = r; we_b = w; addr_b = a; wdata_b = d;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    set_a(1'b1, 1'b1, 4'd0, 16'h0A0A);
    set_b(1'b1, 1'b1, 4'd0, 16'h0B0B);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if ({gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, rf_wr_en, rf_rd_en, rf_address, rf_wr_data} !== '0)
        begin errors++; $display("FAIL reset_outputs cycle %0d: gnt %b%b rvalid %b%b rf_wr %b rf_rd %b addr %h wdata %h, required all 0",
                                 c, gnt_a, gnt_b, rvalid_a, rvalid_b, rf_wr_en, rf_rd_en, rf_address, rf_wr_data); end
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      errors++; $display("FAIL reset_first_gnt: gnt_a %b gnt_b %b, required 1 0", gnt_a, gnt_b);
    end
    exp_mem[0] = 16'h0A0A;
    set_a(1'b0, 1'b0, 4'd0, 16'h0000);
    for (int c = 0; c < 6 && gnt_b !== 1'b1; c++) @(negedge CLK);
    checks++;
    if (gnt_b !== 1'b1) begin errors++; $display("FAIL reset_second_gnt: gnt_b %b, required 1", gnt_b); end
    exp_mem[0] = 16'h0B0B;
    set_b(1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
  endtask

  task automatic test_single();
    logic [DW-1:0] e;
    set_a(1'b1, 1'b1, 4'd2, 16'h0003);
    @(negedge CLK);
    checks++;
    if (gnt_a !== 1'b1 || rf_wr_en !== 1'b1 || rf_rd_en !== 1'b0 || rf_address !== 4'd2 || rf_wr_data !== 16'h0003) begin
      errors++; $display("FAIL single_write: gnt_a %b wr %b rd %b addr %h data %h, required 1 1 0 2 0003",
                         gnt_a, rf_wr_en, rf_rd_en, rf_address, rf_wr_data);
    end
    exp_mem[2] = 16'h0003;
    set_a(1'b1, 1'b0, 4'd2, 16'h0000);
    q_a.push_back(exp_mem[2]);
    @(negedge CLK);
    checks++;
    if (gnt_a !== 1'b0 || rf_wr_en !== 1'b0 || rf_address !== 4'd0 || rf_wr_data !== 16'h0000) begin
      errors++; $display("FAIL single_idle_gap: gnt_a %b wr %b addr %h data %h, required 0 0 0 0000", gnt_a, rf_wr_en, rf_address, rf_wr_data);
    end
    @(negedge CLK);
    checks++;
    if (gnt_a !== 1'b1 || rf_rd_en !== 1'b1 || rf_wr_en !== 1'b0 || rf_address !== 4'd2) begin
      errors++; $display("FAIL single_read_issue: gnt_a %b rd %b wr %b addr %h, required 1 1 0 2", gnt_a, rf_rd_en, rf_wr_en, rf_address);
    end
    set_a(1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    checks++;
    if (rvalid_a !== 1'b0) begin errors++; $display("FAIL single_rvalid_early: rvalid_a %b, required 0", rvalid_a); end
    @(negedge CLK);
    checks++;
    if (rvalid_a !== 1'b1 || rvalid_b !== 1'b0) begin
      errors++; $display("FAIL single_rvalid_latency: rvalid_a %b rvalid_b %b, required 1 0", rvalid_a, rvalid_b);
    end else if (q_a.size() != 0) begin
      e = q_a.pop_front();
      checks++;
      $display("read A data %h expected %h", rdata_a, e);
      if (rdata_a !== e) begin errors++; $display("FAIL single_rdata: rdata_a %h, required %h", rdata_a, e); end
    end
    @(negedge CLK);
  endtask

  task automatic test_tie();
    logic [DW-1:0] e;
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    set_a(1'b1, 1'b1, 4'd1, 16'h1111);
    set_b(1'b1, 1'b1, 4'd1, 16'h2222);
    @(negedge CLK);
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || rf_wr_data !== 16'h1111) begin
      errors++; $display("FAIL tie_first: gnt_a %b gnt_b %b data %h, required 1 0 1111", gnt_a, gnt_b, rf_wr_data);
    end
    exp_mem[1] = 16'h1111;
    set_a(1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || rf_wr_data !== 16'h2222) begin
      errors++; $display("FAIL tie_second: gnt_a %b gnt_b %b data %h, required 0 1 2222", gnt_a, gnt_b, rf_wr_data);
    end
    exp_mem[1] = 16'h2222;
    set_b(1'b0, 1'b0, 4'd0, 16'h0000);
    set_a(1'b1, 1'b0, 4'd1, 16'h0000);
    q_a.push_back(exp_mem[1]);
    @(negedge CLK);
    for (int c = 0; c < 6 && gnt_a !== 1'b1; c++) @(negedge CLK);
    set_a(1'b0, 1'b0, 4'd0, 16'h0000);
    for (int c = 0; c < 6 && rvalid_a !== 1'b1; c++) @(negedge CLK);
    checks++;
    if (rvalid_a !== 1'b1 || q_a.size() == 0) begin
      errors++; $display("FAIL tie_readback_timeout: rvalid_a %b, required 1", rvalid_a);
    end else begin
      e = q_a.pop_front();
      $display("read A data %h expected %h", rdata_a, e);
      if (rdata_a !== e) begin errors++; $display("FAIL tie_readback: rdata_a %h, required %h", rdata_a, e); end
    end
    @(negedge CLK);
  endtask

  task automatic test_fairness();
    int   ga = 0;
    int   gb = 0;
    logic exp_id = 1'b0;
    logic [DW-1:0] e;
    // A then B write alone, so B was served last and A wins the first tie.
    set_a(1'b1, 1'b1, 4'd3, 16'h3333);
    for (int c = 0; c < 6 && gnt_a !== 1'b1; c++) @(negedge CLK);
    exp_mem[3] = 16'h3333;
    set_a(1'b0, 1'b0, 4'd0, 16'h0000);
    set_b(1'b1, 1'b1, 4'd4, 16'h4444);
    @(negedge CLK);
    for (int c = 0; c < 6 && gnt_b !== 1'b1; c++) @(negedge CLK);
    exp_mem[4] = 16'h4444;
    set_a(1'b1, 1'b0, 4'd3, 16'h0000); q_a.push_back(exp_mem[3]);
    set_b(1'b1, 1'b0, 4'd4, 16'h0000); q_b.push_back(exp_mem[4]);
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (gnt_a === 1'b1 || gnt_b === 1'b1) begin
        checks++;
        if (gnt_a === gnt_b || gnt_b !== exp_id) begin
          errors++; $display("FAIL fair_order: gnt_a %b gnt_b %b, required grant to %s", gnt_a, gnt_b, exp_id ? "B" : "A");
        end
        exp_id = ~exp_id;
      end
      if (gnt_a === 1'b1) begin
        ga++;
        if (ga < 4) q_a.push_back(exp_mem[3]); else set_a(1'b0, 1'b0, 4'd0, 16'h0000);
      end
      if (gnt_b === 1'b1) begin
        gb++;
        if (gb < 4) q_b.push_back(exp_mem[4]); else set_b(1'b0, 1'b0, 4'd0, 16'h0000);
      end
      if (rvalid_a === 1'b1 || rvalid_b === 1'b1) begin
        checks++;
        if (rvalid_a === rvalid_b) begin errors++; $display("FAIL fair_rvalid_excl: rvalid_a %b rvalid_b %b, required one-hot", rvalid_a, rvalid_b); end
      end
      if (rvalid_a === 1'b1 && q_a.size() != 0) begin
        e = q_a.pop_front();
        checks++;
        $display("read A data %h expected %h", rdata_a, e);
        if (rdata_a !== e) begin errors++; $display("FAIL fair_rdata_a: rdata_a %h, required %h", rdata_a, e); end
      end
      if (rvalid_b === 1'b1 && q_b.size() != 0) begin
        e = q_b.pop_front();
        checks++;
        $display("read B data %h expected %h", rdata_b, e);
        if (rdata_b !== e) begin errors++; $display("FAIL fair_rdata_b: rdata_b %h, required %h", rdata_b, e); end
      end
      if (ga >= 4 && gb >= 4 && q_a.size() == 0 && q_b.size() == 0) break;
    end
    checks++;
    if (ga != 4 || gb != 4 || q_a.size() != 0 || q_b.size() != 0) begin
      errors++; $display("FAIL fair_drain: grants A %0d B %0d pending A %0d B %0d, required 4 4 0 0", ga, gb, q_a.size(), q_b.size());
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] e;
    set_a(1'b1, 1'b0, 4'd2, 16'h0000);
    for (int c = 0; c < 6 && gnt_a !== 1'b1; c++) @(negedge CLK);
    set_a(1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (rvalid_a !== 1'b0 || rdata_a !== 16'h0000 || gnt_a !== 1'b0 || rf_rd_en !== 1'b0) begin
        errors++; $display("FAIL midrst_outputs: rvalid_a %b rdata_a %h gnt_a %b rd %b, required 0 0000 0 0", rvalid_a, rdata_a, gnt_a, rf_rd_en);
      end
    end
    RST = 1'b1;
    set_b(1'b1, 1'b1, 4'd5, 16'hBEEF);
    @(negedge CLK);
    checks++;
    if (gnt_b !== 1'b1 || rf_wr_en !== 1'b1 || rf_address !== 4'd5 || rf_wr_data !== 16'hBEEF || rvalid_a !== 1'b0) begin
      errors++; $display("FAIL midrst_write: gnt_b %b wr %b addr %h data %h rvalid_a %b, required 1 1 5 beef 0",
                         gnt_b, rf_wr_en, rf_address, rf_wr_data, rvalid_a);
    end
    exp_mem[5] = 16'hBEEF;
    set_b(1'b1, 1'b0, 4'd5, 16'h0000);
    q_b.push_back(exp_mem[5]);
    @(negedge CLK);
    for (int c = 0; c < 6 && gnt_b !== 1'b1; c++) @(negedge CLK);
    set_b(1'b0, 1'b0, 4'd0, 16'h0000);
    for (int c = 0; c < 6 && rvalid_b !== 1'b1; c++) @(negedge CLK);
    checks++;
    if (rvalid_b !== 1'b1 || q_b.size() == 0) begin
      errors++; $display("FAIL midrst_readback_timeout: rvalid_b %b, required 1", rvalid_b);
    end else begin
      e = q_b.pop_front();
      $display("read B data %h expected %h", rdata_b, e);
      if (rdata_b !== e) begin errors++; $display("FAIL midrst_readback: rdata_b %h, required %h", rdata_b, e); end
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int g = 0;
    logic [DW-1:0] e;
    set_a(1'b1, 1'b1, 4'd7, 16'h7777);
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      if (gnt_a === 1'b1) begin
        g++;
        if (g == 1) begin
          checks++;
          if (rf_wr_en !== 1'b1 || rf_wr_data !== 16'h7777 || rf_address !== 4'd7) begin
            errors++; $display("FAIL b2b_write: wr %b addr %h data %h, required 1 7 7777", rf_wr_en, rf_address, rf_wr_data);
          end
          exp_mem[7] = 16'h7777;
          set_a(1'b1, 1'b0, 4'd7, 16'h0000);
          q_a.push_back(exp_mem[7]);
        end else begin
          set_a(1'b0, 1'b0, 4'd0, 16'h0000);
        end
      end
      if (rvalid_a === 1'b1 && q_a.size() != 0) begin
        e = q_a.pop_front();
        checks++;
        $display("read A data %h expected %h", rdata_a, e);
        if (rdata_a !== e) begin errors++; $display("FAIL b2b_rdata: rdata_a %h, required %h", rdata_a, e); end
      end
    end
    checks++;
    if (g != 2 || q_a.size() != 0) begin
      errors++; $display("FAIL b2b_grants: grants %0d pending %0d, required 2 0", g, q_a.size());
    end
  endtask

  initial begin
    set_a(1'b0, 1'b0, 4'd0, 16'h0000);
    set_b(1'b0, 1'b0, 4'd0, 16'h0000);
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 16-entry x 16-bit register file (ports WrData, Address, WrEn, RdEn, RdData).
- Accepts one read or write command per requester, serialises the commands onto the single register-file port, and steers read data back to the requester that issued the read.
- Sits between the control logic (requesters A and B) and the register file instance.

Parameters:
DATA_W  16  data width; matches register file WrData/RdData
ADDR_W  4  address width; matches register file Address

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST  input  1  reset; asynchronous, active-low
req_a  input  1  requester A command valid; held until gnt_a is seen
we_a  input  1  A command type: 1 = write, 0 = read
addr_a  input  ADDR_W  A register address
wdata_a  input  DATA_W  A write data
gnt_a  output  1  one-cycle pulse: A command issued to the register file
rvalid_a  output  1  one-cycle pulse: rdata_a valid
rdata_a  output  DATA_W  A read data; holds last value
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
rf_wr_en  output  1  to register file WrEn
rf_rd_en  output  1  to register file RdEn
rf_address  output  ADDR_W  to register file Address
rf_wr_data  output  DATA_W  to register file WrData
rf_rd_data  input  DATA_W  from register file RdData; valid the cycle after the edge that samples RdEn

Behaviour:
- All outputs are registered.
- Reset (RST = 0, async):
  - All outputs go to 0.
  - State goes to IDLE.
  - Round-robin pointer is set so A wins the first tie.
  - Any in-flight command is discarded; no gnt or rvalid is produced for it.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE, at edge k:
  - No request: stay in IDLE.
  - Exactly one req high: select that requester.
  - Both high: select the requester not served last; the pointer flips after each grant.
  - On a selection: latch we/addr/wdata of the winner and go to ISSUE.
- ISSUE, cycle k..k+1:
  - gnt_x = 1 for the winner.
  - Write: rf_wr_en = 1, rf_wr_data = latched wdata.
  - Read: rf_rd_en = 1.
  - rf_address = latched addr.
  - The register file samples the command at edge k+1.
  - Next state: write goes to IDLE; read goes to RD_WAIT.
- RD_WAIT, at edge k+2:
  - rdata_x <= rf_rd_data.
  - rvalid_x = 1 for cycle k+2..k+3.
  - Go to IDLE.
- Outside ISSUE: rf_wr_en = rf_rd_en = 0, rf_address = 0, rf_wr_data = 0.
- Latency and throughput:
  - Write: gnt one cycle after req is sampled; sustained rate 1 command per 2 cycles.
  - Read: data two cycles after gnt; sustained rate 1 command per 3 cycles.
- Requester rules:
  - A requester drops req, or presents a new command, at the edge where it sees gnt.
  - req is never sampled in ISSUE or RD_WAIT, so no double grant can occur.
- Write ordering: writes are committed in grant order. A read granted after a write to the same address returns the new data.
- Changing a command while req is high and before gnt is a protocol violation; the values sampled at the IDLE edge are used.
- gnt_a and gnt_b are never high together; rvalid_a and rvalid_b are never high together.

Decomposition:
- Package rf_arb_pkg:
  - state enum {IDLE, ISSUE, RD_WAIT}
  - DATA_W and ADDR_W defaults
  - requester-id constants REQ_A = 0, REQ_B = 1
- Sub-module rr_arb2:
  - 2-way round-robin picker.
  - Inputs: req_a, req_b, pointer, advance strobe.
  - Outputs: winner id, any_req.
  - Pointer register lives inside rr_arb2 and is reset by RST.
- Top level: FSM, command latch, output registers, and the register file interface.

Test Plan:
- Reset: hold RST = 0 with req_a = req_b = 1 -> all outputs 0, no gnt. Release -> first gnt goes to A.
- Single requester: A writes 0x0003 to address 2 -> gnt_a, rf_wr_en, rf_address = 2 and rf_wr_data = 0x0003 all high in the same cycle. A then reads address 2 -> rvalid_a two cycles after gnt_a, rdata_a = 0x0003.
- Tie:
  - A (write 0x1111 to address 1) and B (write 0x2222 to address 1) are raised in the same cycle after reset -> gnt_a first, gnt_b two cycles later.
  - A then reads address 1 -> rdata_a = 0x2222.
- Fairness: both requesters keep req high with reads to addresses 3 and 4 -> grants alternate A, B, A, B. Each rvalid goes only to its own requester with the correct data.
- Reset mid-read: assert RST during RD_WAIT -> rvalid_a stays 0 and the FSM returns to IDLE. After release, a new B write to address 5 with 0xBEEF completes, and a readback returns 0xBEEF.
- Back-to-back: A holds a write, then a read of the same address, with no idle cycle between them -> the read returns the freshly written value, and there is exactly one gnt per command.
